uart_rx_fifo: RTL

- Receive-side byte buffer that sits directly downstream of `uart_rx`.
- Captures each byte flagged by `rx_end`/`rx_data` into a circular FIFO and presents it to a consumer through a first-word-fall-through pop interface.
- Tracks how many complete lines (0x0A-terminated) are buffered and flags overflow.
- Used both in `chip_top` (ahead of the UART bus slave) and in the testbench console path, so characters are never lost while the consumer is busy.

---
 rtl/uart_rx_fifo.sv | 121 ++++++++++++
 1 files changed

// File: rtl/uart_rx_fifo.sv
// Receive byte FIFO behind uart_rx: first-word-fall-through pop, buffered-line count, sticky overflow.
// Optional build macro UART_RX_FIFO_CR_STRIP_EN discards received 0x0D bytes before they reach the FIFO.
module uart_rx_fifo #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rx_end,
    input  logic [DATA_W-1:0] rx_data,
    input  logic              rd_en,
    input  logic              ovf_clr,
    output logic [DATA_W-1:0] rd_data,
    output logic              empty,
    output logic              full,
    output logic [ADDR_W:0]   count,
    output logic [ADDR_W:0]   line_cnt,
    output logic              line_ready,
    output logic              overflow
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W:0]   COUNT_FULL = (ADDR_W+1)'(DEPTH);
    localparam logic [DATA_W-1:0] LF_BYTE    = DATA_W'(8'h0A);

    logic [DATA_W-1:0] mem_reg [DEPTH];
    logic [ADDR_W-1:0] wr_ptr_reg, wr_ptr_next;
    logic [ADDR_W-1:0] rd_ptr_reg, rd_ptr_next;
    logic [ADDR_W:0]   count_reg, count_next;
    logic [ADDR_W:0]   line_cnt_reg, line_cnt_next;
    logic              overflow_reg, overflow_next;

    logic byte_keep;
    logic rx_valid;
    logic wr_acc;
    logic rd_acc;
    logic drop;
    logic lf_in;
    logic lf_out;

`ifdef UART_RX_FIFO_CR_STRIP_EN
    localparam logic [DATA_W-1:0] CR_BYTE = DATA_W'(8'h0D);
    assign byte_keep = (rx_data != CR_BYTE);
`else
    assign byte_keep = 1'b1;
`endif

    assign empty      = (count_reg == '0);
    assign full       = (count_reg == COUNT_FULL);
    assign rd_acc     = rd_en & ~empty;
    assign rx_valid   = rx_end & byte_keep;
    // A pop in the same cycle frees the slot, so a full FIFO can still take the byte.
    assign wr_acc     = rx_valid & (~full | rd_acc);
    assign drop       = rx_valid & full & ~rd_acc;
    assign rd_data    = mem_reg[rd_ptr_reg];
    assign lf_in      = wr_acc & (rx_data == LF_BYTE);
    assign lf_out     = rd_acc & (rd_data == LF_BYTE);

    assign count      = count_reg;
    assign line_cnt   = line_cnt_reg;
    assign line_ready = (line_cnt_reg != '0);
    assign overflow   = overflow_reg;

    always_comb begin
        wr_ptr_next   = wr_ptr_reg;
        rd_ptr_next   = rd_ptr_reg;
        count_next    = count_reg;
        line_cnt_next = line_cnt_reg;
        overflow_next = overflow_reg;

        if (wr_acc) begin
            wr_ptr_next = wr_ptr_reg + ADDR_W'(1);
        end
        if (rd_acc) begin
            rd_ptr_next = rd_ptr_reg + ADDR_W'(1);
        end

        case ({wr_acc, rd_acc})
            2'b10:   count_next = count_reg + (ADDR_W+1)'(1);
            2'b01:   count_next = count_reg - (ADDR_W+1)'(1);
            default: count_next = count_reg;
        endcase

        case ({lf_in, lf_out})
            2'b10:   line_cnt_next = line_cnt_reg + (ADDR_W+1)'(1);
            2'b01:   line_cnt_next = line_cnt_reg - (ADDR_W+1)'(1);
            default: line_cnt_next = line_cnt_reg;
        endcase

        // A fresh drop beats a clear arriving in the same cycle.
        if (drop) begin
            overflow_next = 1'b1;
        end else if (ovf_clr) begin
            overflow_next = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            line_cnt_reg <= '0;
            overflow_reg <= 1'b0;
        end else begin
            wr_ptr_reg   <= wr_ptr_next;
            rd_ptr_reg   <= rd_ptr_next;
            count_reg    <= count_next;
            line_cnt_reg <= line_cnt_next;
            overflow_reg <= overflow_next;
        end
    end

    // Storage contents are don't-care after reset, so the array carries no reset.
    always_ff @(posedge clk) begin
        if (wr_acc && !reset) begin
            mem_reg[wr_ptr_reg] <= rx_data;
        end
    end

endmodule
